// File: rtl/vx_uuid_tracker.sv
`default_nettype none
// ============================================================================
// Module   : vx_uuid_tracker
// Purpose  : Tracks in-flight instruction UUIDs per warp for one core.
//            Sequence numbers are checked at issue and at commit, the number
//            outstanding per warp is bounded, and errors go out through a
//            registered valid/ready report port.
// Ports    : clk, reset (async, active high)
//            issue_valid/issue_uuid/issue_ready   - issue stream (backpressured)
//            commit_valid/commit_uuid             - commit stream (no backpressure)
//            err_valid/err_ready/err_code/err_uuid - error report handshake
//            err_dropped                          - saturating lost-error count
//            perf_issued/perf_committed           - 64-bit event counters
// Config   : define UUID_TRACKER_PERF_EN to build the perf counters; otherwise
//            both perf outputs are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module vx_uuid_tracker #(
  parameter int CORE_ID         = 0,
  parameter int MAX_OUTSTANDING = 16,
  parameter int NUM_WARPS       = 4,
  parameter int UUID_WIDTH      = 40
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  issue_valid,
  input  logic [UUID_WIDTH-1:0] issue_uuid,
  output logic                  issue_ready,
  input  logic                  commit_valid,
  input  logic [UUID_WIDTH-1:0] commit_uuid,
  output logic                  err_valid,
  input  logic                  err_ready,
  output logic [1:0]            err_code,
  output logic [UUID_WIDTH-1:0] err_uuid,
  output logic [7:0]            err_dropped,
  output logic [63:0]           perf_issued,
  output logic [63:0]           perf_committed
);

  localparam int          NW_BITS          = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int          GW_BITS          = UUID_WIDTH - 32;
  localparam logic [7:0]  C_OUT_MAX        = 8'(MAX_OUTSTANDING);
  localparam logic [1:0]  C_CORE_MISMATCH  = 2'd0;
  localparam logic [1:0]  C_ISSUE_SEQ      = 2'd1;
  localparam logic [1:0]  C_COMMIT_SEQ     = 2'd2;
  localparam logic [1:0]  C_UNDERFLOW      = 2'd3;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_REPORT = 1'b1} state_t;

  // UUID decode
  logic [GW_BITS-1:0] i_gwid, c_gwid;
  logic [NW_BITS-1:0] i_wid, c_wid;
  logic [31:0]        i_seq, c_seq;
  logic               i_core_ok, c_core_ok;

  assign i_gwid    = issue_uuid[UUID_WIDTH-1:32];
  assign c_gwid    = commit_uuid[UUID_WIDTH-1:32];
  assign i_wid     = i_gwid[NW_BITS-1:0];
  assign c_wid     = c_gwid[NW_BITS-1:0];
  assign i_seq     = issue_uuid[31:0];
  assign c_seq     = commit_uuid[31:0];
  assign i_core_ok = ((i_gwid >> NW_BITS) == GW_BITS'(CORE_ID));
  assign c_core_ok = ((c_gwid >> NW_BITS) == GW_BITS'(CORE_ID));

  // Per-warp state
  logic [31:0] exp_issue_q   [NUM_WARPS];
  logic [31:0] exp_issue_d   [NUM_WARPS];
  logic [31:0] exp_commit_q  [NUM_WARPS];
  logic [31:0] exp_commit_d  [NUM_WARPS];
  logic [7:0]  outstanding_q [NUM_WARPS];
  logic [7:0]  outstanding_d [NUM_WARPS];

  // Reset forces ready high combinationally so the issuer never stalls on it.
  assign issue_ready = reset || (outstanding_q[i_wid] != C_OUT_MAX);

  logic       i_fire, i_apply, i_err, c_apply, c_err, c_under;
  logic [1:0] i_code, c_code;

  assign i_fire  = issue_valid && issue_ready;
  assign i_apply = i_fire && i_core_ok;
  assign i_err   = i_fire && (!i_core_ok || (i_seq != exp_issue_q[i_wid]));
  assign i_code  = i_core_ok ? C_ISSUE_SEQ : C_CORE_MISMATCH;

  assign c_under = (outstanding_q[c_wid] == 8'd0);
  assign c_apply = commit_valid && c_core_ok && !c_under;
  assign c_err   = commit_valid && (!c_core_ok || c_under || (c_seq != exp_commit_q[c_wid]));
  assign c_code  = !c_core_ok ? C_CORE_MISMATCH : (c_under ? C_UNDERFLOW : C_COMMIT_SEQ);

  // Issue and commit both read pre-cycle state, so a same-warp pair nets out.
  always_comb begin
    exp_issue_d   = exp_issue_q;
    exp_commit_d  = exp_commit_q;
    outstanding_d = outstanding_q;
    if (i_apply) exp_issue_d[i_wid]  = i_seq + 32'd1;
    if (c_apply) exp_commit_d[c_wid] = c_seq + 32'd1;
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (i_apply && (i_wid == NW_BITS'(w))) outstanding_d[w] = outstanding_d[w] + 8'd1;
      if (c_apply && (c_wid == NW_BITS'(w))) outstanding_d[w] = outstanding_d[w] - 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        exp_issue_q[w]   <= 32'd1;
        exp_commit_q[w]  <= 32'd1;
        outstanding_q[w] <= 8'd0;
      end
    end else begin
      exp_issue_q   <= exp_issue_d;
      exp_commit_q  <= exp_commit_d;
      outstanding_q <= outstanding_d;
    end
  end

  // Error reporter
  state_t                state_q, state_d;
  logic [1:0]            err_code_q, err_code_d;
  logic [UUID_WIDTH-1:0] err_uuid_q, err_uuid_d;
  logic [7:0]            dropped_q, dropped_d;
  logic [1:0]            n_err, n_drop;
  logic [8:0]            drop_sum;

  assign n_err = {1'b0, c_err} + {1'b0, i_err};

  always_comb begin
    state_d    = state_q;
    err_code_d = err_code_q;
    err_uuid_d = err_uuid_q;
    n_drop     = 2'd0;
    case (state_q)
      ST_IDLE: begin
        if (n_err != 2'd0) begin
          state_d = ST_REPORT;
          // Commit errors outrank issue errors; the loser is dropped.
          if (c_err) begin
            err_code_d = c_code;
            err_uuid_d = commit_uuid;
          end else begin
            err_code_d = i_code;
            err_uuid_d = issue_uuid;
          end
          n_drop = n_err - 2'd1;
        end
      end
      ST_REPORT: begin
        // Everything seen while a report is pending is lost, handshake cycle included.
        n_drop = n_err;
        if (err_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    drop_sum  = {1'b0, dropped_q} + {7'd0, n_drop};
    dropped_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      err_code_q <= 2'd0;
      err_uuid_q <= '0;
      dropped_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      err_code_q <= err_code_d;
      err_uuid_q <= err_uuid_d;
      dropped_q  <= dropped_d;
    end
  end

  assign err_valid   = (state_q == ST_REPORT);
  assign err_code    = err_code_q;
  assign err_uuid    = err_uuid_q;
  assign err_dropped = dropped_q;

`ifdef UUID_TRACKER_PERF_EN
  logic [63:0] perf_issued_q, perf_issued_d;
  logic [63:0] perf_committed_q, perf_committed_d;

  always_comb begin
    perf_issued_d    = perf_issued_q + (i_apply ? 64'd1 : 64'd0);
    perf_committed_d = perf_committed_q + (c_apply ? 64'd1 : 64'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_issued_q    <= 64'd0;
      perf_committed_q <= 64'd0;
    end else begin
      perf_issued_q    <= perf_issued_d;
      perf_committed_q <= perf_committed_d;
    end
  end

  assign perf_issued    = perf_issued_q;
  assign perf_committed = perf_committed_q;
`else
  assign perf_issued    = 64'd0;
  assign perf_committed = 64'd0;
`endif

endmodule
`default_nettype wire
